// File: rtl/pipeline_hazard_scheduler_if.sv
// Handshake bundle between the ID-stage control unit and the hazard scheduler.
// The control side is the master; the scheduler is the slave.
interface pipeline_hazard_scheduler_if;
    logic       id_valid;
    logic [4:0] id_src0;
    logic [4:0] id_src1;
    logic       id_src0_en;
    logic       id_src1_en;
    logic [4:0] id_dst;
    logic       id_dst_en;
    logic       id_branch_jump;
    logic       wb_valid;
    logic [4:0] wb_dst;
    logic       taken;
    logic       drain_req;
    logic       pc_write;
    logic       stall;
    logic       flush;
    logic       issue;
    logic       drain_done;
    logic       sb_err;

    modport master (
        output id_valid, id_src0, id_src1, id_src0_en, id_src1_en, id_dst, id_dst_en,
               id_branch_jump, wb_valid, wb_dst, taken, drain_req,
        input  pc_write, stall, flush, issue, drain_done, sb_err
    );

    modport slave (
        input  id_valid, id_src0, id_src1, id_src0_en, id_src1_en, id_dst, id_dst_en,
               id_branch_jump, wb_valid, wb_dst, taken, drain_req,
        output pc_write, stall, flush, issue, drain_done, sb_err
    );
endinterface

// File: rtl/pipeline_hazard_scheduler.sv
// Scoreboard stall/flush/drain scheduler for the 5-stage pipeline: counts in-flight
// writers per register, stalls dependents, sequences branch flushes and drains.
module pipeline_hazard_scheduler #(
    parameter int NUM_REGS     = 32,
    parameter int ADR_REG      = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pipeline_hazard_scheduler_if.slave  bus
);
    localparam int FW = 2;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [FW-1:0]    FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [FW-1:0]     fcnt, fcnt_nxt;
    logic [CNT_W-1:0]  cnt_q [1:NUM_REGS-1];
    logic [CNT_W-1:0]  cnt   [NUM_REGS];
    logic              any_pending;
    logic              hazard;
    logic              wb_err;
    logic              sb_err_q;
    logic [NUM_REGS-1:1] inc_hit, dec_hit;
    logic              issue_c, stall_c, flush_c, pc_write_c, drain_done_c;

    // Register 0 reads as a permanently idle counter so lookups need no special case.
    always_comb begin
        cnt[0]      = '0;
        any_pending = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt[r]      = cnt_q[r];
            any_pending = any_pending | (cnt_q[r] != '0);
        end
    end

    assign hazard = bus.id_valid &
                    ((bus.id_src0_en    & (cnt[bus.id_src0] != '0)) |
                     (bus.id_src1_en    & (cnt[bus.id_src1] != '0)) |
                     (bus.id_branch_jump & (cnt[ADR_REG]    != '0)) |
                     (bus.id_dst_en     & (cnt[bus.id_dst]  == CNT_MAX)));

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        fcnt_nxt     = fcnt;
        issue_c      = 1'b0;
        stall_c      = 1'b0;
        flush_c      = 1'b0;
        pc_write_c   = 1'b1;
        drain_done_c = 1'b0;
        unique case (state)
            RUN: begin
                issue_c    = bus.id_valid & ~hazard & ~bus.taken & ~bus.drain_req;
                stall_c    = bus.id_valid & hazard & ~bus.taken;
                pc_write_c = ~stall_c;
                if (bus.taken) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = FLUSH_LOAD;
                end else if (bus.drain_req) begin
                    state_nxt = DRAIN;
                end
            end
            FLUSH: begin
                flush_c = 1'b1;
                if (bus.taken)           fcnt_nxt  = FLUSH_LOAD;
                else if (fcnt == '0)     state_nxt = bus.drain_req ? DRAIN : RUN;
                else                     fcnt_nxt  = fcnt - 1'b1;
            end
            DRAIN: begin
                stall_c      = 1'b1;
                pc_write_c   = 1'b0;
                drain_done_c = ~any_pending & ~bus.wb_valid;
                if (bus.taken) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = FLUSH_LOAD;
                end else if (!bus.drain_req) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
        // Reset must not let an ID instruction issue or stall while the pipe is held.
        if (!rst_n) begin
            issue_c    = 1'b0;
            stall_c    = 1'b0;
            pc_write_c = 1'b1;
        end
    end

    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        if (issue_c && bus.id_dst_en && bus.id_dst != '0) inc_hit[bus.id_dst] = 1'b1;
        if (bus.wb_valid && bus.wb_dst != '0)             dec_hit[bus.wb_dst] = 1'b1;
    end

    assign wb_err = bus.wb_valid & (bus.wb_dst != '0) & (cnt[bus.wb_dst] == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // NOTE: the counter array is reset explicitly; a reset mid-flight must forget
    // every pending writer, so this storage cannot be left uninitialised like a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NUM_REGS; r++) cnt_q[r] <= '0;
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc_hit[r] && !dec_hit[r])
                    cnt_q[r] <= cnt_q[r] + 1'b1;
                else if (dec_hit[r] && !inc_hit[r] && cnt_q[r] != '0)
                    cnt_q[r] <= cnt_q[r] - 1'b1;
            end
            sb_err_q <= sb_err_q | wb_err;
        end
    end

    assign bus.issue      = issue_c;
    assign bus.stall      = stall_c;
    assign bus.flush      = flush_c;
    assign bus.pc_write   = pc_write_c;
    assign bus.drain_done = drain_done_c;
    assign bus.sb_err     = sb_err_q;
endmodule

// File: tb/tb_pipeline_hazard_scheduler.sv
// Bench for pipeline_hazard_scheduler: directed scenarios plus randomized traffic,
// all compared every cycle against a pending-writer reference model.
module tb_pipeline_hazard_scheduler;
  localparam int FC   = 2;
  localparam int NR   = 32;
  localparam int ADR  = 4;
  localparam int CMAX = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  pipeline_hazard_scheduler_if bus ();

  pipeline_hazard_scheduler #(
    .NUM_REGS(NR), .ADR_REG(ADR), .FLUSH_CYCLES(FC), .CNT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding writes per register, remaining flush cycles, drain mode.
  int   pend [NR];
  int   flush_left;
  bit   draining;
  bit   err_m;
  bit   e_issue, e_stall, e_flush, e_pc, e_dd;
  logic o_issue, o_stall, o_flush, o_pc, o_dd, o_err;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (pend[r]) pend[r] = 0;
    flush_left = 0;
    draining   = 1'b0;
    err_m      = 1'b0;
  endtask

  task automatic predict();
    int outstanding = 0;
    bit hz;
    foreach (pend[r]) outstanding += pend[r];
    hz = bus.id_valid && ((bus.id_src0_en && pend[bus.id_src0] > 0) ||
                          (bus.id_src1_en && pend[bus.id_src1] > 0) ||
                          (bus.id_branch_jump && pend[ADR] > 0) ||
                          (bus.id_dst_en && pend[bus.id_dst] == CMAX));
    e_issue = 1'b0; e_stall = 1'b0; e_flush = 1'b0; e_pc = 1'b1; e_dd = 1'b0;
    if (flush_left > 0) begin
      e_flush = 1'b1;
    end else if (draining) begin
      e_stall = 1'b1;
      e_pc    = 1'b0;
      e_dd    = (outstanding == 0) && !bus.wb_valid;
    end else begin
      e_issue = bus.id_valid && !hz && !bus.taken && !bus.drain_req;
      e_stall = bus.id_valid && hz && !bus.taken;
      e_pc    = !e_stall;
    end
  endtask

  task automatic advance();
    int d   = int'(bus.id_dst);
    int w   = int'(bus.wb_dst);
    bit inc = e_issue && bus.id_dst_en && d != 0;
    bit dec = bus.wb_valid && w != 0;
    if (dec && pend[w] == 0) err_m = 1'b1;
    if (!(inc && dec && d == w)) begin
      if (inc) pend[d]++;
      if (dec && pend[w] > 0) pend[w]--;
    end
    if (flush_left > 0) begin
      if (bus.taken) flush_left = FC;
      else begin
        flush_left--;
        if (flush_left == 0) draining = bus.drain_req;
      end
    end else if (draining) begin
      if (bus.taken) begin flush_left = FC; draining = 1'b0; end
      else if (!bus.drain_req) draining = 1'b0;
    end else begin
      if (bus.taken) flush_left = FC;
      else if (bus.drain_req) draining = 1'b1;
    end
  endtask

  task automatic sample();
    o_issue = bus.issue; o_stall = bus.stall; o_flush = bus.flush;
    o_pc = bus.pc_write; o_dd = bus.drain_done; o_err = bus.sb_err;
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic cycle();
    #1;
    predict();
    sample();
    check("issue",      int'(o_issue), int'(e_issue));
    check("stall",      int'(o_stall), int'(e_stall));
    check("flush",      int'(o_flush), int'(e_flush));
    check("pc_write",   int'(o_pc),    int'(e_pc));
    check("drain_done", int'(o_dd),    int'(e_dd));
    check("sb_err",     int'(o_err),   int'(err_m));
    @(posedge clk);
    advance();
    cyc++;
    @(negedge clk);
  endtask

  task automatic instr(input int v, input int s0, input int s0e, input int s1, input int s1e,
                       input int d, input int de, input int bj);
    bus.id_valid       = v[0];
    bus.id_src0        = 5'(s0);
    bus.id_src0_en     = s0e[0];
    bus.id_src1        = 5'(s1);
    bus.id_src1_en     = s1e[0];
    bus.id_dst         = 5'(d);
    bus.id_dst_en      = de[0];
    bus.id_branch_jump = bj[0];
  endtask

  task automatic wb(input int v, input int r);
    bus.wb_valid = v[0];
    bus.wb_dst   = 5'(r);
  endtask

  task automatic idle();
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0);
    bus.taken     = 1'b0;
    bus.drain_req = 1'b0;
  endtask

  initial begin
    int stalls, issued_at, flushes, first_dd;
    int cands[$];
    idle();
    model_reset();

    // Reset state, with an instruction presented so reset gating is visible.
    @(negedge clk);
    instr(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    sample();
    check("rst_pc_write", int'(o_pc), 1);
    check("rst_stall",    int'(o_stall), 0);
    check("rst_flush",    int'(o_flush), 0);
    check("rst_issue",    int'(o_issue), 0);
    check("rst_drain",    int'(o_dd), 0);
    check("rst_sb_err",   int'(o_err), 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back RAW on r5, producer retires three cycles after issue.
    instr(1, 0, 0, 0, 0, 5, 1, 0);
    cycle();
    check("raw_producer_issue", int'(o_issue), 1);
    stalls = 0; issued_at = -1;
    for (int k = 1; k <= 6 && issued_at < 0; k++) begin
      instr(1, 5, 1, 0, 0, 0, 0, 0);
      wb(k == 3, 5);
      cycle();
      if (o_stall && !o_pc) stalls++;
      if (o_issue) issued_at = k;
    end
    check("raw_stall_cycles", stalls, 3);
    check("raw_issue_cycle", issued_at, 4);
    idle();

    // Branch/jump waits for a pending $adr writer.
    instr(1, 0, 0, 0, 0, ADR, 1, 0);
    cycle();
    stalls = 0; issued_at = -1;
    for (int k = 1; k <= 6 && issued_at < 0; k++) begin
      instr(1, 0, 0, 0, 0, 0, 0, 1);
      wb(k == 2, ADR);
      cycle();
      if (o_stall) stalls++;
      if (o_issue) issued_at = k;
    end
    check("bj_stall_cycles", stalls, 2);
    check("bj_issue_cycle", issued_at, 3);
    idle();

    // Taken branch: r12 pending survives the flush, the r13 writer in the taken cycle never issues.
    instr(1, 0, 0, 0, 0, 12, 1, 0);
    cycle();
    instr(1, 0, 0, 0, 0, 13, 1, 0);
    bus.taken = 1'b1;
    cycle();
    check("taken_issue", int'(o_issue), 0);
    check("taken_stall", int'(o_stall), 0);
    bus.taken = 1'b0;
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    flushes = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (o_flush) flushes++;
    end
    check("flush_cycles", flushes, FC);
    instr(1, 12, 1, 13, 1, 0, 0, 0);
    cycle();
    check("flush_sb_kept", int'(o_stall), 1);
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 12);
    cycle();
    wb(0, 0);
    instr(1, 13, 1, 0, 0, 0, 0, 0);
    cycle();
    check("flush_no_rollback", int'(o_issue), 1);

    // r7: same-cycle issue+writeback keeps the count, saturation blocks the fourth writer.
    instr(1, 0, 0, 0, 0, 7, 1, 0);
    cycle();
    wb(1, 7);
    cycle();
    check("r7_same_cycle_issue", int'(o_issue), 1);
    wb(0, 0);
    cycle();
    cycle();
    cycle();
    check("r7_saturation_stall", int'(o_stall), 1);
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 7);
    repeat (3) cycle();
    wb(0, 0);

    // Drain with two writes in flight.
    instr(1, 0, 0, 0, 0, 10, 1, 0);
    cycle();
    instr(1, 0, 0, 0, 0, 11, 1, 0);
    cycle();
    instr(1, 0, 0, 0, 0, 0, 0, 0);
    bus.drain_req = 1'b1;
    cycle();
    check("drain_blocks_issue", int'(o_issue), 0);
    first_dd = -1;
    for (int k = 1; k <= 6; k++) begin
      wb(k == 1 || k == 3, (k == 1) ? 10 : 11);
      cycle();
      if (o_dd && first_dd < 0) first_dd = k;
    end
    check("drain_done_cycle", first_dd, 4);
    wb(0, 0);
    bus.drain_req = 1'b0;
    cycle();
    cycle();
    check("drain_exit_issue", int'(o_issue), 1);
    idle();

    // Writeback to an idle register is sticky.
    wb(1, 9);
    cycle();
    wb(0, 0);
    cycle();
    check("sb_err_set", int'(o_err), 1);
    cycle();
    check("sb_err_sticky", int'(o_err), 1);

    // Asynchronous reset in the middle of a flush.
    bus.taken = 1'b1;
    cycle();
    bus.taken = 1'b0;
    cycle();
    check("pre_reset_flush", int'(o_flush), 1);
    #2 rst_n = 1'b0;
    #1;
    sample();
    check("mid_flush_rst_flush",    int'(o_flush), 0);
    check("mid_flush_rst_pc_write", int'(o_pc), 1);
    check("mid_flush_rst_sb_err",   int'(o_err), 0);
    check("mid_flush_rst_stall",    int'(o_stall), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic; writebacks only target registers the model holds as in flight.
    for (int n = 0; n < 3000; n++) begin
      instr(int'($urandom_range(9) < 7),
            int'($urandom_range(7)), int'($urandom_range(1)),
            int'($urandom_range(7)), int'($urandom_range(1)),
            int'($urandom_range(7)), int'($urandom_range(3) != 0),
            int'($urandom_range(4) == 0));
      bus.taken = ($urandom_range(19) == 0);
      if ($urandom_range(29) == 0) bus.drain_req = !bus.drain_req;
      cands.delete();
      for (int r = 1; r < 8; r++) if (pend[r] > 0) cands.push_back(r);
      if (cands.size() > 0 && $urandom_range(9) < 4)
        wb(1, cands[$urandom_range(cands.size() - 1)]);
      else
        wb(0, int'($urandom_range(31)));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
